// File: rtl/tag_ram_pkg.sv
// Shared encodings and entry helpers for the tag RAM controller.
// Entries are {state[1:0], tag}; the helpers take the entry zero-extended
// to 32 bits plus the real entry width, so entries up to 32 bits are supported.
package tag_ram_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'b00,
    OP_FILL       = 2'b01,
    OP_SETSTATE   = 2'b10,
    OP_LOOKUP_ALT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MSI_I    = 2'b00,
    MSI_S    = 2'b01,
    MSI_M    = 2'b10,
    MSI_RSVD = 2'b11
  } msi_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_CMP  = 2'b10
  } fsm_e;

  localparam int unsigned STATE_W = 2;

  function automatic logic [1:0] entry_state(input logic [31:0] entry,
                                             input int unsigned dwidth);
    return 2'((entry >> (dwidth - STATE_W)) & 32'd3);
  endfunction

  function automatic logic [31:0] entry_tag(input logic [31:0] entry,
                                            input int unsigned dwidth);
    return entry & ((32'd1 << (dwidth - STATE_W)) - 32'd1);
  endfunction

  function automatic logic [31:0] entry_pack(input logic [1:0] state,
                                             input logic [31:0] tag,
                                             input int unsigned dwidth);
    return (32'(state) << (dwidth - STATE_W)) | entry_tag(tag, dwidth);
  endfunction

endpackage

// File: rtl/tag_ram_prio_arb.sv
// Two-way arbiter: snoop wins by default, but after MAX_SNP_STREAK snoop
// grants with the CPU waiting, the CPU takes the next arbitration.
// The select outputs are purely combinational; i_grant_en tells the streak
// counter when a select actually became a grant.
module tag_ram_prio_arb #(
  parameter int unsigned MAX_SNP_STREAK = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_cpu_req,
  input  logic i_snp_req,
  input  logic i_grant_en,
  output logic o_sel_cpu,
  output logic o_sel_snp
);

  localparam int unsigned SW = (MAX_SNP_STREAK < 1) ? 1 : $clog2(MAX_SNP_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_SNP_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_cpu_turn;

  // CPU wins when snoop is idle or snoop has used up its streak
  always_comb begin
    w_cpu_turn = (r_streak >= STREAK_MAX);
    o_sel_cpu  = i_cpu_req & (~i_snp_req | w_cpu_turn);
    o_sel_snp  = i_snp_req & ~o_sel_cpu;
  end

  // Count snoop grants taken while the CPU waits; clear when CPU served or idle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_streak <= '0;
    end else if (!i_cpu_req) begin
      r_streak <= '0;
    end else if (i_grant_en && o_sel_cpu) begin
      r_streak <= '0;
    end else if (i_grant_en && o_sel_snp && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Sequencer for one tag RAM bank shared by the CPU and snoop requesters.
// After reset it sweeps every entry to {I, 0}, then serves one operation per
// two cycles: IDLE launches the read (or the FILL write), CMP consumes the
// read data, answers the owner and commits a SETSTATE on a hit.
//
// Handshake: a requester raises *_req with op/index/tag/state stable and keeps
// them until it sees *_gnt high on a clock edge; that edge accepts the request.
// *_resp_valid pulses for exactly one cycle, the cycle after the grant.
// All outputs are forced to zero while reset is high.
module tag_ram_ctrl
  import tag_ram_pkg::*;
#(
  parameter int unsigned AWIDTH         = 3,
  parameter int unsigned DWIDTH         = 11,
  parameter int unsigned MAX_SNP_STREAK = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_op,
  input  logic [AWIDTH-1:0] cpu_index,
  input  logic [DWIDTH-3:0] cpu_tag,
  input  logic [1:0]        cpu_state,
  output logic              cpu_gnt,
  output logic              cpu_resp_valid,
  input  logic              snp_req,
  input  logic [1:0]        snp_op,
  input  logic [AWIDTH-1:0] snp_index,
  input  logic [DWIDTH-3:0] snp_tag,
  input  logic [1:0]        snp_state,
  output logic              snp_gnt,
  output logic              snp_resp_valid,
  output logic              resp_hit,
  output logic [1:0]        resp_state,
  output logic [DWIDTH-3:0] resp_tag,
  output logic              init_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output fsm_e              o_dbg_state
);

  localparam int unsigned TWIDTH = DWIDTH - 2;
  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  fsm_e              r_state;
  fsm_e              w_next;
  logic [AWIDTH-1:0] r_init_idx;
  logic              r_init_done;
  logic              r_owner_snp;
  logic [1:0]        r_op;
  logic [1:0]        r_new_st;
  logic [AWIDTH-1:0] r_index;
  logic [TWIDTH-1:0] r_tag;

  logic              w_is_idle;
  logic              w_sel_cpu;
  logic              w_sel_snp;
  logic              w_grant;
  logic [1:0]        w_req_op;
  logic [1:0]        w_req_st;
  logic [AWIDTH-1:0] w_req_idx;
  logic [TWIDTH-1:0] w_req_tag;
  logic [1:0]        w_stored_st;
  logic [TWIDTH-1:0] w_stored_tag;
  logic              w_hit;

  assign w_is_idle   = (r_state == ST_IDLE) & ~reset;
  assign w_grant     = w_is_idle & (w_sel_cpu | w_sel_snp);
  assign init_done   = r_init_done & ~reset;
  assign o_dbg_state = r_state;

  tag_ram_prio_arb #(
    .MAX_SNP_STREAK (MAX_SNP_STREAK)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .i_cpu_req  (cpu_req),
    .i_snp_req  (snp_req),
    .i_grant_en (w_is_idle),
    .o_sel_cpu  (w_sel_cpu),
    .o_sel_snp  (w_sel_snp)
  );

  // Route the winning requester's fields
  always_comb begin
    w_req_op  = w_sel_cpu ? cpu_op    : snp_op;
    w_req_st  = w_sel_cpu ? cpu_state : snp_state;
    w_req_idx = w_sel_cpu ? cpu_index : snp_index;
    w_req_tag = w_sel_cpu ? cpu_tag   : snp_tag;
  end

  // Split the read entry and compare it with the latched request tag
  always_comb begin
    w_stored_st  = entry_state(32'(ram_dout), DWIDTH);
    w_stored_tag = TWIDTH'(entry_tag(32'(ram_dout), DWIDTH));
    w_hit        = (w_stored_st != MSI_I) && (w_stored_tag == r_tag);
  end

  // FSM state, sweep counter and init flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT) begin
        r_init_idx <= r_init_idx + 1'b1;
        if (r_init_idx == LAST_IDX) begin
          r_init_done <= 1'b1;
        end
      end
    end
  end

  // Capture the accepted request for use in CMP
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner_snp <= 1'b0;
      r_op        <= OP_LOOKUP;
      r_new_st    <= MSI_I;
      r_index     <= '0;
      r_tag       <= '0;
    end else if (w_grant) begin
      r_owner_snp <= w_sel_snp;
      r_op        <= w_req_op;
      r_new_st    <= w_req_st;
      r_index     <= w_req_idx;
      r_tag       <= w_req_tag;
    end
  end

  // Next state and all RAM / handshake outputs
  always_comb begin
    w_next         = r_state;
    cpu_gnt        = 1'b0;
    snp_gnt        = 1'b0;
    cpu_resp_valid = 1'b0;
    snp_resp_valid = 1'b0;
    resp_hit       = 1'b0;
    resp_state     = 2'b00;
    resp_tag       = '0;
    ram_addr       = '0;
    ram_din        = '0;
    ram_we         = 1'b0;
    if (!reset) begin
      unique case (r_state)
        ST_INIT: begin
          ram_we   = 1'b1;
          ram_addr = r_init_idx;
          if (r_init_idx == LAST_IDX) begin
            w_next = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_grant) begin
            cpu_gnt  = w_sel_cpu;
            snp_gnt  = w_sel_snp;
            ram_addr = w_req_idx;
            if (w_req_op == OP_FILL) begin
              ram_we  = 1'b1;
              ram_din = DWIDTH'(entry_pack(w_req_st, 32'(w_req_tag), DWIDTH));
            end
            w_next = ST_CMP;
          end
        end
        ST_CMP: begin
          cpu_resp_valid = ~r_owner_snp;
          snp_resp_valid = r_owner_snp;
          ram_addr       = r_index;
          if (r_op == OP_FILL) begin
            // The FILL already wrote in IDLE; report what was written
            resp_hit   = 1'b1;
            resp_state = r_new_st;
            resp_tag   = r_tag;
          end else begin
            resp_hit   = w_hit;
            resp_state = w_stored_st;
            resp_tag   = w_stored_tag;
            if ((r_op == OP_SETSTATE) && w_hit) begin
              ram_we  = 1'b1;
              ram_din = DWIDTH'(entry_pack(r_new_st, 32'(w_stored_tag), DWIDTH));
            end
          end
          w_next = ST_IDLE;
        end
        default: begin
          w_next = ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Bench for tag_ram_ctrl: a sync-read RAM, directed scenarios, randomized
// CPU/snoop traffic, and a monitor that predicts grants, responses and RAM
// writes from an array-based model of the tag contents.
module tb_tag_ram_ctrl;
  import tag_ram_pkg::*;

  localparam int AW         = 3;
  localparam int DW         = 11;
  localparam int TW         = DW - 2;
  localparam int DEPTH      = 1 << AW;
  localparam int MAX_STREAK = 2;
  localparam int EW         = DW + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic [1:0]    cpu_op = 2'b00;
  logic [AW-1:0] cpu_index = '0;
  logic [TW-1:0] cpu_tag = '0;
  logic [1:0]    cpu_state = 2'b00;
  logic          snp_req = 1'b0;
  logic [1:0]    snp_op = 2'b00;
  logic [AW-1:0] snp_index = '0;
  logic [TW-1:0] snp_tag = '0;
  logic [1:0]    snp_state = 2'b00;
  logic          cpu_gnt, snp_gnt, cpu_resp_valid, snp_resp_valid;
  logic          resp_hit, init_done, ram_we;
  logic [1:0]    resp_state;
  logic [TW-1:0] resp_tag;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  fsm_e          dbg_state;

  logic [DW-1:0] ram_mem [DEPTH];

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic          gnt_log[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            cyc = 0;
  int            streak = 0;
  bit            in_cmp = 1'b0;
  logic          cmp_we = 1'b0;
  logic [AW-1:0] cmp_addr = '0;
  logic [DW-1:0] cmp_din = '0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Tag RAM: one-cycle synchronous read, write on the clock edge
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  tag_ram_ctrl #(
    .AWIDTH         (AW),
    .DWIDTH         (DW),
    .MAX_SNP_STREAK (MAX_STREAK)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_op         (cpu_op),
    .cpu_index      (cpu_index),
    .cpu_tag        (cpu_tag),
    .cpu_state      (cpu_state),
    .cpu_gnt        (cpu_gnt),
    .cpu_resp_valid (cpu_resp_valid),
    .snp_req        (snp_req),
    .snp_op         (snp_op),
    .snp_index      (snp_index),
    .snp_tag        (snp_tag),
    .snp_state      (snp_state),
    .snp_gnt        (snp_gnt),
    .snp_resp_valid (snp_resp_valid),
    .resp_hit       (resp_hit),
    .resp_state     (resp_state),
    .resp_tag       (resp_tag),
    .init_done      (init_done),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_we         (ram_we),
    .ram_dout       (ram_dout),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin : monitor
    logic [EW-1:0] e;
    logic          cg, sg, ready, hit, exp_we;
    logic [1:0]    s_op, s_st;
    logic [AW-1:0] s_idx, exp_addr;
    logic [TW-1:0] s_tag;
    logic [DW-1:0] stored, exp_din;
    if (reset) begin
      check("reset_outputs",
            32'({cpu_gnt, snp_gnt, cpu_resp_valid, snp_resp_valid, ram_we, init_done,
                 resp_hit, resp_state, resp_tag, ram_addr}), 32'd0);
      exp_q.delete();
      cyc    = 0;
      streak = 0;
      in_cmp = 1'b0;
      cmp_we = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      ready = (cyc >= DEPTH) && !in_cmp;
      check("init_done_level", 32'(init_done), 32'(cyc >= DEPTH));
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_din  = '0;
      if (cyc < DEPTH) begin
        exp_we   = 1'b1;
        exp_addr = AW'(cyc);
      end
      // response owed for last cycle's grant
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("resp_valid", 32'({cpu_resp_valid, snp_resp_valid}), e[EW-1] ? 32'd1 : 32'd2);
        check("resp_data", 32'({resp_hit, resp_state, resp_tag}), 32'(e[EW-2:0]));
        exp_we   = cmp_we;
        exp_addr = cmp_addr;
        exp_din  = cmp_din;
      end else begin
        check("resp_quiet", 32'({cpu_resp_valid, snp_resp_valid}), 32'd0);
      end
      // arbitration: snoop first unless the CPU has waited through a full streak
      cg = 1'b0;
      sg = 1'b0;
      if (ready && (cpu_req || snp_req)) begin
        if (cpu_req && (!snp_req || streak >= MAX_STREAK)) cg = 1'b1;
        else sg = 1'b1;
      end
      check("gnt", 32'({cpu_gnt, snp_gnt}), 32'({cg, sg}));
      if (!cpu_req || cg) streak = 0;
      else if (sg) streak++;
      in_cmp = cg || sg;
      cmp_we = 1'b0;
      if (cg || sg) begin
        gnt_log.push_back(cpu_gnt);
        s_op   = cg ? cpu_op    : snp_op;
        s_st   = cg ? cpu_state : snp_state;
        s_idx  = cg ? cpu_index : snp_index;
        s_tag  = cg ? cpu_tag   : snp_tag;
        stored = model_mem[s_idx];
        check("rd_addr", 32'(ram_addr), 32'(s_idx));
        if (s_op == OP_FILL) begin
          exp_q.push_back({sg, 1'b1, s_st, s_tag});
          model_mem[s_idx] = {s_st, s_tag};
          exp_we   = 1'b1;
          exp_addr = s_idx;
          exp_din  = {s_st, s_tag};
        end else begin
          hit = (stored[DW-1:TW] != 2'b00) && (stored[TW-1:0] == s_tag);
          exp_q.push_back({sg, hit, stored});
          if (s_op == OP_SETSTATE && hit) begin
            cmp_we   = 1'b1;
            cmp_addr = s_idx;
            cmp_din  = {s_st, stored[TW-1:0]};
            model_mem[s_idx] = {s_st, stored[TW-1:0]};
          end
        end
      end
      check("ram_write",
            32'({ram_we, ram_we ? ram_addr : {AW{1'b0}}, ram_we ? ram_din : {DW{1'b0}}}),
            32'({exp_we, exp_we ? exp_addr : {AW{1'b0}}, exp_we ? exp_din : {DW{1'b0}}}));
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  // Post one request, hold it until granted, return what the CMP cycle showed
  task automatic issue(input bit snp, input logic [1:0] op, input logic [AW-1:0] idx,
                       input logic [TW-1:0] tag, input logic [1:0] st,
                       output logic hit, output logic [1:0] rst,
                       output logic [TW-1:0] rtag, output logic we);
    bit got;
    got = 1'b0;
    if (snp) begin
      snp_op = op; snp_index = idx; snp_tag = tag; snp_state = st; snp_req = 1'b1;
    end else begin
      cpu_op = op; cpu_index = idx; cpu_tag = tag; cpu_state = st; cpu_req = 1'b1;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = snp ? snp_gnt : cpu_gnt;
    end
    check("gnt_wait", 32'(got), 32'd1);
    @(posedge clock);
    #1;
    if (snp) snp_req = 1'b0;
    else cpu_req = 1'b0;
    @(negedge clock);
    hit  = resp_hit;
    rst  = resp_state;
    rtag = resp_tag;
    we   = ram_we;
  endtask

  // Called just after reset drops: the sweep writes 0 to every index in order
  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      check("sweep_write", 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, AW'(i), {DW{1'b0}}}));
      check("sweep_quiet", 32'({cpu_gnt, snp_gnt, init_done}), 32'd0);
    end
    @(negedge clock);
    check("init_done_rise", 32'(init_done), 32'd1);
  endtask

  function automatic logic [TW-1:0] pick_tag();
    case ($urandom_range(0, 3))
      0:       return 9'h1A5;
      1:       return 9'h1A4;
      2:       return 9'h000;
      default: return TW'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    logic          h, w, cg, sg, got;
    logic [1:0]    s;
    logic [TW-1:0] t;
    logic          exp_order [6];

    // reset with a snoop already waiting: it must not be granted during the sweep
    reset     = 1'b1;
    snp_op    = OP_LOOKUP;
    snp_index = 3'd3;
    snp_tag   = 9'h000;
    snp_req   = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_sweep();
    check("first_gnt_snp", 32'(snp_gnt), 32'd1);
    @(posedge clock);
    #1 snp_req = 1'b0;

    // FILL then LOOKUP hit / miss
    issue(1'b0, OP_FILL, 3'd3, 9'h1A5, MSI_M, h, s, t, w);
    check("fill_resp", 32'({h, s, t}), 32'({1'b1, 2'b10, 9'h1A5}));
    issue(1'b0, OP_LOOKUP, 3'd3, 9'h1A5, MSI_I, h, s, t, w);
    check("lookup_hit", 32'({h, s, t}), 32'({1'b1, 2'b10, 9'h1A5}));
    issue(1'b0, OP_LOOKUP, 3'd3, 9'h1A4, MSI_I, h, s, t, w);
    check("lookup_miss", 32'({h, s, t}), 32'({1'b0, 2'b10, 9'h1A5}));

    // snoop SETSTATE hit: reports old state, writes in CMP
    issue(1'b1, OP_SETSTATE, 3'd3, 9'h1A5, MSI_S, h, s, t, w);
    check("setstate_hit_resp", 32'({h, s, t}), 32'({1'b1, 2'b10, 9'h1A5}));
    check("setstate_hit_we", 32'(w), 32'd1);
    issue(1'b0, OP_LOOKUP, 3'd3, 9'h1A5, MSI_I, h, s, t, w);
    check("after_setstate", 32'({h, s, t}), 32'({1'b1, 2'b01, 9'h1A5}));

    // SETSTATE miss: no write, entry unchanged
    issue(1'b1, OP_SETSTATE, 3'd3, 9'h0AA, MSI_M, h, s, t, w);
    check("setstate_miss_resp", 32'({h, s, t}), 32'({1'b0, 2'b01, 9'h1A5}));
    check("setstate_miss_we", 32'(w), 32'd0);
    issue(1'b1, 2'b11, 3'd3, 9'h1A5, MSI_M, h, s, t, w);
    check("op11_lookup", 32'({h, s, t, w}), 32'({1'b1, 2'b01, 9'h1A5, 1'b0}));
    issue(1'b0, OP_LOOKUP, 3'd0, 9'h000, MSI_I, h, s, t, w);
    check("swept_entry_invalid", 32'({h, s, t}), 32'({1'b0, 2'b00, 9'h000}));

    // both requesters held: snp, snp, cpu, snp, snp, cpu
    exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    gnt_log.delete();
    cpu_op = OP_LOOKUP; cpu_index = 3'd1; cpu_tag = 9'h011;
    snp_op = OP_LOOKUP; snp_index = 3'd2; snp_tag = 9'h022;
    cpu_req = 1'b1;
    snp_req = 1'b1;
    for (int n = 0; n < 40 && gnt_log.size() < 6; n++) @(negedge clock);
    @(posedge clock);
    #1;
    cpu_req = 1'b0;
    snp_req = 1'b0;
    check("arb_count", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
      check("arb_order", 32'(gnt_log[i]), 32'(exp_order[i]));
    end

    // randomized traffic, each side obeys hold-until-grant
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      cg = cpu_gnt;
      sg = snp_gnt;
      @(posedge clock);
      #1;
      if (cg) cpu_req = 1'b0;
      if (sg) snp_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_op    = 2'($urandom_range(0, 3));
        cpu_index = AW'($urandom_range(0, 3));
        cpu_tag   = pick_tag();
        cpu_state = 2'($urandom_range(0, 3));
        cpu_req   = 1'b1;
      end
      if (!snp_req && $urandom_range(0, 2) == 0) begin
        snp_op    = 2'($urandom_range(0, 3));
        snp_index = AW'($urandom_range(0, 3));
        snp_tag   = pick_tag();
        snp_state = 2'($urandom_range(0, 3));
        snp_req   = 1'b1;
      end
    end
    for (int n = 0; n < 20 && (cpu_req || snp_req); n++) begin
      @(negedge clock);
      cg = cpu_gnt;
      sg = snp_gnt;
      @(posedge clock);
      #1;
      if (cg) cpu_req = 1'b0;
      if (sg) snp_req = 1'b0;
    end
    check("drain", 32'({cpu_req, snp_req}), 32'd0);
    @(negedge clock);

    // reset during the CMP of a SETSTATE hit
    issue(1'b0, OP_FILL, 3'd5, 9'h155, MSI_S, h, s, t, w);
    snp_op = OP_SETSTATE; snp_index = 3'd5; snp_tag = 9'h155; snp_state = MSI_M;
    snp_req = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = snp_gnt;
    end
    check("rst_setup_gnt", 32'(got), 32'd1);
    @(posedge clock);
    #1;
    snp_req = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    check("rst_in_cmp", 32'({snp_resp_valid, cpu_resp_valid, ram_we}), 32'd0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1 reset = 1'b0;
    check_sweep();
    issue(1'b0, OP_LOOKUP, 3'd5, 9'h155, MSI_I, h, s, t, w);
    check("after_rst_lookup", 32'({h, s, t}), 32'({1'b0, 2'b00, 9'h000}));

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
